// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the datapath (master) and the stall/flush
// sequencer (slave). The master drives hazard status and the slave drives the
// hold/flush/redirect controls. Defining HAZARD_PERF_EN adds the perf counters.
interface pipeline_hazard_ctrl_if #(
  parameter int unsigned REG_ADDR_W = 5
`ifdef HAZARD_PERF_EN
  , parameter int unsigned PERF_W = 32
`endif
);
  // Hazard status from the datapath
  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_rs1_addr;
  logic [REG_ADDR_W-1:0] id_rs2_addr;
  logic                  id_rs1_used;
  logic                  id_rs2_used;
  logic                  ex_valid;
  logic                  ex_is_load;
  logic [REG_ADDR_W-1:0] ex_rd_addr;
  logic                  ex_busy;
  logic                  ex_redirect;
  logic                  mem_busy;

  // Stage controls back to the datapath
  logic                  pc_hold;
  logic                  pc_redirect;
  logic                  if_id_hold;
  logic                  if_id_flush;
  logic                  id_ex_hold;
  logic                  id_ex_flush;
  logic                  ex_mem_hold;
  logic                  ex_mem_flush;
  logic                  mem_wb_flush;
  logic [1:0]            state_o;
`ifdef HAZARD_PERF_EN
  logic [PERF_W-1:0]     perf_stall_cycles;
  logic [PERF_W-1:0]     perf_loaduse_cnt;
  logic [PERF_W-1:0]     perf_redirect_cnt;
`endif

  modport master (
    output id_valid, id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
           ex_valid, ex_is_load, ex_rd_addr, ex_busy, ex_redirect, mem_busy,
    input  pc_hold, pc_redirect, if_id_hold, if_id_flush, id_ex_hold,
           id_ex_flush, ex_mem_hold, ex_mem_flush, mem_wb_flush, state_o
`ifdef HAZARD_PERF_EN
    , input perf_stall_cycles, perf_loaduse_cnt, perf_redirect_cnt
`endif
  );

  modport slave (
    input  id_valid, id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
           ex_valid, ex_is_load, ex_rd_addr, ex_busy, ex_redirect, mem_busy,
    output pc_hold, pc_redirect, if_id_hold, if_id_flush, id_ex_hold,
           id_ex_flush, ex_mem_hold, ex_mem_flush, mem_wb_flush, state_o
`ifdef HAZARD_PERF_EN
    , output perf_stall_cycles, perf_loaduse_cnt, perf_redirect_cnt
`endif
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage RV32 pipeline.
// Outputs are combinational from the registered state and the current hazard
// inputs. Priority: mem_busy > ex_busy > redirect > load-use. After reset the
// pipe is drained for RESET_FLUSH_CYCLES cycles.
// Optional feature macro: HAZARD_PERF_EN (stall / load-use / redirect counters).
module pipeline_hazard_ctrl #(
  parameter int unsigned RESET_FLUSH_CYCLES = 2,
  parameter int unsigned REG_ADDR_W         = 5
`ifdef HAZARD_PERF_EN
  , parameter int unsigned PERF_W           = 32
`endif
) (
  input logic                   clk,
  input logic                   rst,
  pipeline_hazard_ctrl_if.slave hz
);

  typedef enum logic [1:0] {
    S_INIT     = 2'd0,
    S_RUN      = 2'd1,
    S_EX_WAIT  = 2'd2,
    S_MEM_WAIT = 2'd3
  } state_e;

  localparam logic [REG_ADDR_W-1:0] X0_ADDR = '0;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       load_use;

  // A load writing a register the ID instruction reads; x0 never counts.
  assign load_use = hz.ex_valid && hz.ex_is_load && (hz.ex_rd_addr != X0_ADDR) &&
                    hz.id_valid &&
                    ((hz.id_rs1_used && (hz.id_rs1_addr == hz.ex_rd_addr)) ||
                     (hz.id_rs2_used && (hz.id_rs2_addr == hz.ex_rd_addr)));

  // Priority-ordered stall/flush decode and next-state selection.
  always_comb begin
    // NOTE: every output gets a default first so no branch can infer a latch.
    hz.pc_hold      = 1'b0;
    hz.pc_redirect  = 1'b0;
    hz.if_id_hold   = 1'b0;
    hz.if_id_flush  = 1'b0;
    hz.id_ex_hold   = 1'b0;
    hz.id_ex_flush  = 1'b0;
    hz.ex_mem_hold  = 1'b0;
    hz.ex_mem_flush = 1'b0;
    hz.mem_wb_flush = 1'b0;
    state_d         = state_q;
    cnt_d           = cnt_q;

    if (rst || (state_q == S_INIT)) begin
      // Drain: freeze the PC and bubble every stage register.
      hz.pc_hold      = 1'b1;
      hz.if_id_flush  = 1'b1;
      hz.id_ex_flush  = 1'b1;
      hz.ex_mem_flush = 1'b1;
      hz.mem_wb_flush = 1'b1;
      if (cnt_q <= 4'd1) state_d = S_RUN;
      else               cnt_d   = cnt_q - 4'd1;
    end else if (hz.mem_busy) begin
      hz.pc_hold      = 1'b1;
      hz.if_id_hold   = 1'b1;
      hz.id_ex_hold   = 1'b1;
      hz.ex_mem_hold  = 1'b1;
      hz.mem_wb_flush = 1'b1;
      state_d         = S_MEM_WAIT;
    end else if (hz.ex_busy) begin
      hz.pc_hold      = 1'b1;
      hz.if_id_hold   = 1'b1;
      hz.id_ex_hold   = 1'b1;
      hz.ex_mem_flush = 1'b1;
      state_d         = S_EX_WAIT;
    end else if (hz.ex_redirect && hz.ex_valid) begin
      // The ID instruction is wrong-path, so a coincident load-use is moot.
      hz.pc_redirect  = 1'b1;
      hz.if_id_flush  = 1'b1;
      hz.id_ex_flush  = 1'b1;
      state_d         = S_RUN;
    end else if (load_use) begin
      hz.pc_hold      = 1'b1;
      hz.if_id_hold   = 1'b1;
      hz.id_ex_flush  = 1'b1;
      state_d         = S_RUN;
    end else begin
      state_d         = S_RUN;
    end
  end

  // State and drain counter; synchronous reset re-enters the drain.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q <= S_INIT;
      cnt_q   <= 4'(RESET_FLUSH_CYCLES);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign hz.state_o = state_q;

`ifdef HAZARD_PERF_EN
  logic              stall_evt, lu_evt, red_evt;
  logic [PERF_W-1:0] stall_q, lu_q, red_q;

  // Load-use is the only case combining if_id_hold with id_ex_flush.
  assign stall_evt = hz.pc_hold && !rst && (state_q != S_INIT);
  assign lu_evt    = hz.if_id_hold && hz.id_ex_flush;
  assign red_evt   = hz.pc_redirect;

  // Saturating event counters, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      lu_q    <= '0;
      red_q   <= '0;
    end else begin
      if (stall_evt && (stall_q != '1)) stall_q <= stall_q + PERF_W'(1);
      if (lu_evt    && (lu_q    != '1)) lu_q    <= lu_q    + PERF_W'(1);
      if (red_evt   && (red_q   != '1)) red_q   <= red_q   + PERF_W'(1);
    end
  end

  assign hz.perf_stall_cycles = stall_q;
  assign hz.perf_loaduse_cnt  = lu_q;
  assign hz.perf_redirect_cnt = red_q;
`endif

endmodule
